// File: rtl/fsm_mestre_linha.sv
// Master sequencer for one bottling-line station: conveyor, fill/seal handshakes,
// QC routing, cork alarm, operator stop and per-task timeout supervision.
module fsm_mestre_linha #(
  parameter int unsigned          TIMER_W        = 26,
  parameter logic [TIMER_W-1:0]   TIMEOUT_CICLOS = 26'd50000000,
  parameter logic [TIMER_W-1:0]   TEMPO_LIBERA   = 26'd12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       sensor_garrafa,
  input  logic       sensor_cq,
  input  logic       alarme_rolha,
  input  logic       enchimento_concluido,
  input  logic       vedacao_concluida,
  output logic       motor_esteira,
  output logic       cmd_enchimento,
  output logic       cmd_vedacao,
  output logic       incrementar_duzia,
  output logic       descarte,
  output logic       erro_timeout,
  output logic [2:0] estado_dbg
);

  typedef enum logic [2:0] {
    PARADO       = 3'd0,
    AVANCA       = 3'd1,
    ENCHE        = 3'd2,
    VEDA         = 3'd3,
    LIBERA       = 3'd4,
    ESPERA_ROLHA = 3'd5,
    FALHA        = 3'd6
  } state_t;

  // Limits are compared with >= against (limit - 1) so the exit happens after exactly
  // 'limit' cycles in the state and a smaller limit can never be skipped.
  localparam logic [TIMER_W-1:0] LIM_TIMEOUT = TIMEOUT_CICLOS - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] LIM_LIBERA  = TEMPO_LIBERA - TIMER_W'(1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               conta_c;
  logic               timer_ativo_c;
  logic               timeout_c;

  // Next-state, timer and QC pulse decode; priority stop > timeout > alarm > normal.
  always_comb begin
    state_d       = state_q;
    timer_d       = '0;
    timer_ativo_c = (state_q == ENCHE) || (state_q == VEDA) || (state_q == LIBERA);
    timeout_c     = ((state_q == ENCHE) || (state_q == VEDA)) && (timer_q >= LIM_TIMEOUT);

    if (stop && (state_q != FALHA)) begin
      state_d = PARADO;
    end else if (timeout_c) begin
      state_d = FALHA;
    end else begin
      case (state_q)
        PARADO:       if (start) state_d = AVANCA;
        AVANCA:       if (sensor_garrafa) state_d = ENCHE;
        ENCHE:        if (enchimento_concluido) state_d = alarme_rolha ? ESPERA_ROLHA : VEDA;
        VEDA: begin
          // The sealer aborts on an empty cork stock and never raises done.
          if (alarme_rolha)           state_d = ESPERA_ROLHA;
          else if (vedacao_concluida) state_d = LIBERA;
        end
        LIBERA: begin
          // Waiting for done to return low keeps the next seal req from overlapping it.
          if ((timer_q >= LIM_LIBERA) && !sensor_garrafa && !vedacao_concluida)
            state_d = AVANCA;
        end
        ESPERA_ROLHA: if (!alarme_rolha && start) state_d = VEDA;
        FALHA:        if (start && !stop) state_d = PARADO;
        default:      state_d = PARADO;
      endcase
    end

    // Timer clears on any state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_ativo_c) begin
      timer_d = (timer_q != '1) ? (timer_q + TIMER_W'(1)) : timer_q;
    end

    // Only a real seal completion counts; ESPERA_ROLHA re-entries go to VEDA, not LIBERA.
    conta_c = (state_q == VEDA) && (state_d == LIBERA);
  end

  // State, timer and outputs registered together, outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= PARADO;
      timer_q           <= '0;
      motor_esteira     <= 1'b0;
      cmd_enchimento    <= 1'b0;
      cmd_vedacao       <= 1'b0;
      incrementar_duzia <= 1'b0;
      descarte          <= 1'b0;
      erro_timeout      <= 1'b0;
      estado_dbg        <= 3'd0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      motor_esteira     <= (state_d == AVANCA) || (state_d == LIBERA);
      cmd_enchimento    <= (state_d == ENCHE);
      cmd_vedacao       <= (state_d == VEDA);
      incrementar_duzia <= conta_c && sensor_cq;
      descarte          <= conta_c && !sensor_cq;
      erro_timeout      <= (state_d == FALHA);
      estado_dbg        <= 3'(state_d);
    end
  end

endmodule

// File: tb/tb_fsm_mestre_linha.sv
// Directed bench for fsm_mestre_linha with TIMEOUT_CICLOS=20, TEMPO_LIBERA=4.
module tb_fsm_mestre_linha;

  logic       clk = 1'b0;
  logic       reset, start, stop, sensor_garrafa, sensor_cq, alarme_rolha;
  logic       enchimento_concluido, vedacao_concluida;
  logic       motor_esteira, cmd_enchimento, cmd_vedacao;
  logic       incrementar_duzia, descarte, erro_timeout;
  logic [2:0] estado_dbg;

  int n_total  = 0;
  int n_passed = 0;

  fsm_mestre_linha #(
    .TIMER_W       (26),
    .TIMEOUT_CICLOS(26'd20),
    .TEMPO_LIBERA  (26'd4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .stop                (stop),
    .sensor_garrafa      (sensor_garrafa),
    .sensor_cq           (sensor_cq),
    .alarme_rolha        (alarme_rolha),
    .enchimento_concluido(enchimento_concluido),
    .vedacao_concluida   (vedacao_concluida),
    .motor_esteira       (motor_esteira),
    .cmd_enchimento      (cmd_enchimento),
    .cmd_vedacao         (cmd_vedacao),
    .incrementar_duzia   (incrementar_duzia),
    .descarte            (descarte),
    .erro_timeout        (erro_timeout),
    .estado_dbg          (estado_dbg)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {state, motor, fill req, seal req, count, discard, error} against expected.
  task automatic chk(input string tag, input logic [2:0] st, input logic m, input logic e,
                     input logic v, input logic i, input logic d, input logic r);
    logic [8:0] obs, exp;
    obs = {estado_dbg, motor_esteira, cmd_enchimento, cmd_vedacao,
           incrementar_duzia, descarte, erro_timeout};
    exp = {st, m, e, v, i, d, r};
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%b expected=%b (st,mot,ench,ved,inc,desc,err)", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; sensor_garrafa = 1'b0; sensor_cq = 1'b0;
    alarme_rolha = 1'b0; enchimento_concluido = 1'b0; vedacao_concluida = 1'b0;
    tick(); tick();
    chk("reset_state", 3'd0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 3'd0, 0, 0, 0, 0, 0, 0);

    // 1 nominal cycle
    start = 1'b1; tick();
    chk("n_avanca", 3'd1, 1, 0, 0, 0, 0, 0);
    start = 1'b0; sensor_garrafa = 1'b1; tick();
    chk("n_enche", 3'd2, 0, 1, 0, 0, 0, 0);
    repeat (4) tick();
    chk("n_enche_hold", 3'd2, 0, 1, 0, 0, 0, 0);
    enchimento_concluido = 1'b1; tick();
    chk("n_veda", 3'd3, 0, 0, 1, 0, 0, 0);
    enchimento_concluido = 1'b0;
    repeat (5) tick();
    chk("n_veda_hold", 3'd3, 0, 0, 1, 0, 0, 0);
    vedacao_concluida = 1'b1; sensor_cq = 1'b1; tick();
    chk("n_libera_count", 3'd4, 1, 0, 0, 1, 0, 0);
    vedacao_concluida = 1'b0; sensor_garrafa = 1'b0; tick();
    chk("n_pulse_one_cycle", 3'd4, 1, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("n_libera_t3", 3'd4, 1, 0, 0, 0, 0, 0);
    tick();
    chk("n_back_avanca", 3'd1, 1, 0, 0, 0, 0, 0);

    // 2 reject, plus LIBERA held by a bottle still present
    sensor_garrafa = 1'b1; tick();
    chk("r_enche", 3'd2, 0, 1, 0, 0, 0, 0);
    repeat (4) tick();
    enchimento_concluido = 1'b1; tick();
    chk("r_veda", 3'd3, 0, 0, 1, 0, 0, 0);
    enchimento_concluido = 1'b0;
    repeat (5) tick();
    vedacao_concluida = 1'b1; sensor_cq = 1'b0; tick();
    chk("r_discard", 3'd4, 1, 0, 0, 0, 1, 0);
    vedacao_concluida = 1'b0;
    repeat (5) tick();
    chk("r_held_by_bottle", 3'd4, 1, 0, 0, 0, 0, 0);
    sensor_garrafa = 1'b0; tick();
    chk("r_back_avanca", 3'd1, 1, 0, 0, 0, 0, 0);

    // 3 cork alarm during VEDA
    sensor_garrafa = 1'b1; tick();
    enchimento_concluido = 1'b1; tick();
    chk("a_veda", 3'd3, 0, 0, 1, 0, 0, 0);
    enchimento_concluido = 1'b0; tick();
    alarme_rolha = 1'b1; tick();
    chk("a_espera", 3'd5, 0, 0, 0, 0, 0, 0);
    start = 1'b1; tick();
    chk("a_wait_alarm", 3'd5, 0, 0, 0, 0, 0, 0);
    alarme_rolha = 1'b0; tick();
    chk("a_reenter_veda", 3'd3, 0, 0, 1, 0, 0, 0);
    start = 1'b0;
    vedacao_concluida = 1'b1; sensor_cq = 1'b1; tick();
    chk("a_count", 3'd4, 1, 0, 0, 1, 0, 0);
    vedacao_concluida = 1'b0; sensor_garrafa = 1'b0; tick();
    chk("a_single_pulse", 3'd4, 1, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("a_back_avanca", 3'd1, 1, 0, 0, 0, 0, 0);

    // 4 fill timeout: 20 cycles in ENCHE
    sensor_garrafa = 1'b1; tick();
    chk("t_enche", 3'd2, 0, 1, 0, 0, 0, 0);
    repeat (19) tick();
    chk("t_before_limit", 3'd2, 0, 1, 0, 0, 0, 0);
    tick();
    chk("t_falha", 3'd6, 0, 0, 0, 0, 0, 1);
    sensor_garrafa = 1'b0; stop = 1'b1; tick();
    chk("t_sticky_stop_ignored", 3'd6, 0, 0, 0, 0, 0, 1);
    stop = 1'b0; start = 1'b1; tick();
    chk("t_clear", 3'd0, 0, 0, 0, 0, 0, 0);

    // 5 stop during VEDA
    tick();
    chk("s_restart", 3'd1, 1, 0, 0, 0, 0, 0);
    start = 1'b0; sensor_garrafa = 1'b1; tick();
    enchimento_concluido = 1'b1; tick();
    enchimento_concluido = 1'b0; tick();
    chk("s_veda", 3'd3, 0, 0, 1, 0, 0, 0);
    stop = 1'b1; vedacao_concluida = 1'b1; sensor_cq = 1'b1; tick();
    chk("s_parado_no_pulse", 3'd0, 0, 0, 0, 0, 0, 0);
    vedacao_concluida = 1'b0; sensor_garrafa = 1'b0; start = 1'b1; tick();
    chk("s_start_blocked", 3'd0, 0, 0, 0, 0, 0, 0);
    stop = 1'b0; tick();
    chk("s_restart2", 3'd1, 1, 0, 0, 0, 0, 0);

    // 6 synchronous reset in LIBERA
    start = 1'b0; sensor_garrafa = 1'b1; tick();
    enchimento_concluido = 1'b1; tick();
    enchimento_concluido = 1'b0; vedacao_concluida = 1'b1; tick();
    chk("x_libera", 3'd4, 1, 0, 0, 1, 0, 0);
    vedacao_concluida = 1'b0; sensor_garrafa = 1'b0;
    reset = 1'b1; #2; reset = 1'b0;
    chk("x_glitch_between_edges", 3'd4, 1, 0, 0, 1, 0, 0);
    tick();
    chk("x_glitch_ignored", 3'd4, 1, 0, 0, 0, 0, 0);
    reset = 1'b1; #2;
    chk("x_reset_waits_edge", 3'd4, 1, 0, 0, 0, 0, 0);
    tick();
    chk("x_reset_applied", 3'd0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; tick();
    chk("x_idle", 3'd0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
